regex_instr_mem_responder: RTL and testbench

REGEX_INSTR_MEM_RESPONDER -- requirements
Module: regex_instr_mem_responder

---
 rtl/instruction_package.sv | 23 ++
 rtl/regex_instr_mem_responder_if.sv | 28 ++
 rtl/regex_instr_mem_responder_chk.sv | 19 +
 rtl/regex_instr_ram.sv | 39 +++
 rtl/regex_instr_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_regex_instr_mem_responder.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/instruction_package.sv
// Shared regex_cpu instruction definitions: opcode encodings and the
// instruction-memory responder FSM states.
package instruction_package;

   localparam int OPCODE_WIDTH = 3;

   localparam logic [2:0] OP_CHAR  = 3'd0;
   localparam logic [2:0] OP_MATCH = 3'd1;
   localparam logic [2:0] OP_JMP   = 3'd2;
   localparam logic [2:0] OP_SPLIT = 3'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCEPT  = 2'd1,
      RESPOND = 2'd2
   } state_e;

   // Opcode sits in the top bits of a 20-bit word, operand below it.
   function automatic logic [19:0] make_instr(input logic [2:0] op, input logic [16:0] operand);
      return {op, operand};
   endfunction

endpackage

// File: rtl/regex_instr_mem_responder_if.sv
// Fetch and program-load bus between regex_cpu requesters (master) and the
// instruction memory responder (slave).
interface regex_instr_mem_responder_if #(
   parameter int NUM_PORTS         = 2,
   parameter int MEMORY_WIDTH      = 20,
   parameter int MEMORY_ADDR_WIDTH = 11
);

   logic [NUM_PORTS-1:0]                   memory_valid;
   logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr;
   logic [NUM_PORTS-1:0]                   memory_ready;
   logic [NUM_PORTS*MEMORY_WIDTH-1:0]      memory_data;
   logic                                   load_valid;
   logic [MEMORY_ADDR_WIDTH-1:0]           load_addr;
   logic [MEMORY_WIDTH-1:0]                load_data;
   logic                                   load_ready;

   modport master (
      output memory_valid, memory_addr, load_valid, load_addr, load_data,
      input  memory_ready, memory_data, load_ready
   );

   modport slave (
      input  memory_valid, memory_addr, load_valid, load_addr, load_data,
      output memory_ready, memory_data, load_ready
   );

endinterface

// File: rtl/regex_instr_mem_responder_chk.sv
// Protocol checks for the responder: ready is one-hot-or-zero and only in ACCEPT.
module regex_instr_mem_responder_chk
   import instruction_package::*;
#(
   parameter int NUM_PORTS = 2
) (
   input logic                 clk,
   input logic                 rst,
   input state_e               state,
   input logic [NUM_PORTS-1:0] memory_ready
);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst)
      $onehot0(memory_ready));

   a_ready_only_in_accept: assert property (@(posedge clk) disable iff (!rst)
      (memory_ready != {NUM_PORTS{1'b0}}) |-> (state == ACCEPT));

endmodule

// File: rtl/regex_instr_ram.sv
// Single-write, single-read instruction RAM with a registered read port.
// A read colliding with a write to the same address returns the new word.
module regex_instr_ram #(
   parameter int WIDTH      = 20,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem_r [2**ADDR_WIDTH];
   logic [WIDTH-1:0] rd_data_r;

   // Storage array; deliberately has no reset so programs survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read with write-first bypass.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_r <= wr_data;
         end else begin
            rd_data_r <= mem_r[rd_addr];
         end
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/regex_instr_mem_responder.sv
// Instruction memory responder: serves NUM_PORTS regex_cpu fetch ports from one RAM,
// loads have priority. Define REGEX_MEM_RR_ARB_EN for round-robin grant (default: fixed priority).
module regex_instr_mem_responder
   import instruction_package::*;
#(
   parameter int NUM_PORTS         = 2,
   parameter int MEMORY_WIDTH      = 20,
   parameter int MEMORY_ADDR_WIDTH = 11
) (
   input logic                        clk,
   input logic                        rst,
   regex_instr_mem_responder_if.slave bus
);

   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int W  = MEMORY_WIDTH;
   localparam int AW = MEMORY_ADDR_WIDTH;

   state_e                   state_r;
   logic [GW-1:0]            grant_r;
   logic [GW-1:0]            grant_s;
   logic [NUM_PORTS-1:0]     ready_r;
   logic                     load_ready_r;
   logic [W-1:0]             data_r [NUM_PORTS];
   logic [NUM_PORTS*W-1:0]   data_s;
   logic                     load_fire_s;
   logic                     grant_fire_s;
   logic                     rd_en_s;
   logic [AW-1:0]            rd_addr_s;
   logic [W-1:0]             rd_data_s;

   // The clear of load_ready_r gates a second write while the requester sees its ack.
   assign load_fire_s  = (state_r == IDLE) && bus.load_valid && !load_ready_r;
   assign grant_fire_s = (state_r == IDLE) && !bus.load_valid && (|bus.memory_valid);
   assign rd_en_s      = (state_r == ACCEPT);

`ifdef REGEX_MEM_RR_ARB_EN
   logic [GW-1:0] rr_ptr_r;
   logic [GW:0]   rr_idx_s;

   // Round-robin pick: scan backwards so the port nearest rr_ptr_r wins.
   always_comb begin
      grant_s  = {GW{1'b0}};
      rr_idx_s = {(GW+1){1'b0}};
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         rr_idx_s = {1'b0, rr_ptr_r} + (GW+1)'(k);
         if (rr_idx_s >= (GW+1)'(NUM_PORTS)) begin
            rr_idx_s = rr_idx_s - (GW+1)'(NUM_PORTS);
         end else begin
            rr_idx_s = rr_idx_s;
         end
         if (bus.memory_valid[rr_idx_s[GW-1:0]]) begin
            grant_s = rr_idx_s[GW-1:0];
         end else begin
            grant_s = grant_s;
         end
      end
   end

   // Pointer moves to the port after the one just granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_r <= {GW{1'b0}};
      end else if (grant_fire_s) begin
         if (grant_s == GW'(NUM_PORTS - 1)) begin
            rr_ptr_r <= {GW{1'b0}};
         end else begin
            rr_ptr_r <= grant_s + GW'(1);
         end
      end
   end
`else
   // Fixed priority pick: lowest-index valid port.
   always_comb begin
      grant_s = {GW{1'b0}};
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (bus.memory_valid[k]) begin
            grant_s = GW'(k);
         end else begin
            grant_s = grant_s;
         end
      end
   end
`endif

   // Read address of the granted port.
   always_comb begin
      rd_addr_s = {AW{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant_r == GW'(p)) begin
            rd_addr_s = bus.memory_addr[p*AW +: AW];
         end else begin
            rd_addr_s = rd_addr_s;
         end
      end
   end

   // Fetch FSM: grant capture, ready pulse and per-port response capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         grant_r <= {GW{1'b0}};
         ready_r <= {NUM_PORTS{1'b0}};
         for (int p = 0; p < NUM_PORTS; p++) begin
            data_r[p] <= {W{1'b0}};
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_fire_s) begin
                  state_r <= ACCEPT;
                  grant_r <= grant_s;
                  ready_r <= NUM_PORTS'(1'b1) << grant_s;
               end
            end
            ACCEPT: begin
               ready_r <= {NUM_PORTS{1'b0}};
               state_r <= RESPOND;
            end
            RESPOND: begin
               for (int p = 0; p < NUM_PORTS; p++) begin
                  if (grant_r == GW'(p)) begin
                     data_r[p] <= rd_data_s;
                  end
               end
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               ready_r <= {NUM_PORTS{1'b0}};
            end
         endcase
      end
   end

   // One-cycle load acknowledge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_ready_r <= 1'b0;
      end else begin
         load_ready_r <= load_fire_s;
      end
   end

   // RAM output is forwarded during RESPOND so data shows the cycle after ready.
   always_comb begin
      data_s = {(NUM_PORTS*W){1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
         if ((state_r == RESPOND) && (grant_r == GW'(p))) begin
            data_s[p*W +: W] = rd_data_s;
         end else begin
            data_s[p*W +: W] = data_r[p];
         end
      end
   end

   assign bus.memory_ready = ready_r;
   assign bus.memory_data  = data_s;
   assign bus.load_ready   = load_ready_r;

   regex_instr_ram #(
      .WIDTH      (W),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (load_fire_s),
      .wr_addr (bus.load_addr),
      .wr_data (bus.load_data),
      .rd_en   (rd_en_s),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   regex_instr_mem_responder_chk #(
      .NUM_PORTS (NUM_PORTS)
   ) u_chk (
      .clk          (clk),
      .rst          (rst),
      .state        (state_r),
      .memory_ready (ready_r)
   );

endmodule

// File: tb/tb_regex_instr_mem_responder.sv
// Randomized bench for regex_instr_mem_responder against a word-array memory model
// and a pending-set arbitration model (round-robin when REGEX_MEM_RR_ARB_EN is defined).
module tb_regex_instr_mem_responder;

   localparam int NP = 2;
   localparam int W  = 20;
   localparam int AW = 11;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [W-1:0]  ref_mem  [2**AW];
   logic [W-1:0]  exp_data [NP];
   logic [AW-1:0] req_addr [NP];
   logic [AW-1:0] pool     [8];
`ifdef REGEX_MEM_RR_ARB_EN
   int rr_ptr_m;
`endif

   regex_instr_mem_responder_if #(
      .NUM_PORTS         (NP),
      .MEMORY_WIDTH      (W),
      .MEMORY_ADDR_WIDTH (AW)
   ) bus ();

   regex_instr_mem_responder #(
      .NUM_PORTS         (NP),
      .MEMORY_WIDTH      (W),
      .MEMORY_ADDR_WIDTH (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Next port to serve among those still waiting.
   function automatic int model_pick(input logic [NP-1:0] pend);
      int pick;
      pick = -1;
`ifdef REGEX_MEM_RR_ARB_EN
      for (int k = 0; k < NP; k++) begin
         if (pick < 0 && pend[(rr_ptr_m + k) % NP]) pick = (rr_ptr_m + k) % NP;
      end
`else
      for (int k = 0; k < NP; k++) begin
         if (pick < 0 && pend[k]) pick = k;
      end
`endif
      return pick;
   endfunction

   task automatic do_load(input logic [AW-1:0] a, input logic [W-1:0] d);
      int waited;
      logic seen;
      seen   = 1'b0;
      waited = 0;
      repeat (2) @(negedge clk);
      bus.load_addr  = a;
      bus.load_data  = d;
      bus.load_valid = 1'b1;
      while (!seen && waited < 20) begin
         @(posedge clk); #1;
         waited++;
         if (bus.load_ready) seen = 1'b1;
      end
      bus.load_valid = 1'b0;
      check_val("load_ack", 32'(seen), 32'd1);
      check_val("load_latency", 32'(waited), 32'd1);
      ref_mem[a] = d;
   endtask

   task automatic run_fetch(input logic [NP-1:0] mask);
      logic [NP-1:0] pend;
      logic [W-1:0]  want;
      int cyc;
      int last;
      int g;
      pend = mask;
      cyc  = 0;
      last = -1;
      repeat (2) @(negedge clk);
      for (int q = 0; q < NP; q++) bus.memory_addr[q*AW +: AW] = req_addr[q];
      bus.memory_valid = mask;
      while (pend != '0 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.memory_ready != '0) begin
            g = model_pick(pend);
            check_val("grant", 32'(bus.memory_ready), 32'd1 << g);
            if (last < 0) check_val("fetch_latency", 32'(cyc), 32'd1);
            else          check_val("fetch_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            bus.memory_valid[g] = 1'b0;
            pend[g] = 1'b0;
`ifdef REGEX_MEM_RR_ARB_EN
            rr_ptr_m = (g + 1) % NP;
`endif
            @(posedge clk); #1;
            cyc++;
            check_val("ready_in_respond", 32'(bus.memory_ready), 32'd0);
            for (int q = 0; q < NP; q++) begin
               want = (q == g) ? ref_mem[req_addr[g]] : exp_data[q];
               check_val((q == g) ? "data_hit" : "data_hold", 32'(bus.memory_data[q*W +: W]), 32'(want));
            end
            exp_data[g] = ref_mem[req_addr[g]];
         end
      end
      check_val("fetch_done", 32'(pend), 32'd0);
      bus.memory_valid = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus.memory_valid = '0;
      bus.memory_addr  = '0;
      bus.load_valid   = 1'b0;
      bus.load_addr    = '0;
      bus.load_data    = '0;
      for (int q = 0; q < NP; q++) begin
         exp_data[q] = '0;
         req_addr[q] = '0;
      end
`ifdef REGEX_MEM_RR_ARB_EN
      rr_ptr_m = 0;
`endif
      #12;
      check_val("rst_ready", 32'(bus.memory_ready), 32'd0);
      check_val("rst_load_ready", 32'(bus.load_ready), 32'd0);
      check_val("rst_data", 32'(bus.memory_data), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // JMP|0x0C5 at 0x010 fetched on port 0
      do_load(11'h010, 20'h400C5);
      req_addr[0] = 11'h010;
      run_fetch(2'b01);
      check_val("jmp_word", 32'(bus.memory_data[0 +: W]), 32'h400C5);

      // Both ports at once, twice
      do_load(11'h020, 20'h12345);
      do_load(11'h021, 20'h6789A);
      req_addr[0] = 11'h020;
      req_addr[1] = 11'h021;
      run_fetch(2'b11);
      run_fetch(2'b11);

      // Load and fetch presented together: load wins, fetch sees new word
      repeat (2) @(negedge clk);
      req_addr[1] = 11'h123;
      bus.memory_addr[AW +: AW] = 11'h123;
      bus.load_addr    = 11'h123;
      bus.load_data    = 20'h5A5A5;
      bus.load_valid   = 1'b1;
      bus.memory_valid = 2'b10;
      @(posedge clk); #1;
      check_val("ld_first_load_ready", 32'(bus.load_ready), 32'd1);
      check_val("ld_first_no_fetch", 32'(bus.memory_ready), 32'd0);
      bus.load_valid = 1'b0;
      ref_mem[11'h123] = 20'h5A5A5;
      @(posedge clk); #1;
      check_val("ld_then_fetch_ready", 32'(bus.memory_ready), 32'd2);
      bus.memory_valid = '0;
`ifdef REGEX_MEM_RR_ARB_EN
      rr_ptr_m = 0;
`endif
      @(posedge clk); #1;
      check_val("ld_then_fetch_data", 32'(bus.memory_data[AW*0 + W +: W]), 32'h5A5A5);
      check_val("ld_then_fetch_hold", 32'(bus.memory_data[0 +: W]), 32'(exp_data[0]));
      exp_data[1] = 20'h5A5A5;

      // Top address
      do_load(11'h7FF, 20'hABCDE);
      req_addr[0] = 11'h7FF;
      run_fetch(2'b01);

      // Random loads and fetches over a small address pool
      for (int i = 0; i < 8; i++) begin
         pool[i] = AW'($urandom_range(0, 2**AW - 1));
         do_load(pool[i], W'($urandom));
      end
      for (int it = 0; it < 14; it++) begin
         if ($urandom_range(0, 1) == 1) do_load(pool[$urandom_range(0, 7)], W'($urandom));
         for (int q = 0; q < NP; q++) req_addr[q] = pool[$urandom_range(0, 7)];
         run_fetch(NP'($urandom_range(1, 2**NP - 1)));
      end

      // Reset during ACCEPT aborts the fetch
      repeat (2) @(negedge clk);
      req_addr[0] = 11'h7FF;
      bus.memory_addr[0 +: AW] = 11'h7FF;
      bus.memory_valid = 2'b01;
      @(posedge clk); #1;
      check_val("pre_rst_ready", 32'(bus.memory_ready), 32'd1);
      rst = 1'b0;
      #1;
      check_val("mid_rst_ready", 32'(bus.memory_ready), 32'd0);
      check_val("mid_rst_data", 32'(bus.memory_data), 32'd0);
      bus.memory_valid = '0;
      for (int q = 0; q < NP; q++) exp_data[q] = '0;
`ifdef REGEX_MEM_RR_ARB_EN
      rr_ptr_m = 0;
`endif
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check_val("post_rst_quiet_ready", 32'(bus.memory_ready), 32'd0);
         check_val("post_rst_quiet_data", 32'(bus.memory_data), 32'd0);
      end

      // RAM survives reset
      req_addr[0] = 11'h7FF;
      req_addr[1] = 11'h123;
      run_fetch(2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
